nvm_read_arbiter: RTL and testbench

Shares the single NVM reader (load/shift serial read path) between `NUM_REQ` requesters. A round-robin arbiter grants one requester at a time and pulses `read_en` to the reader with the latched word address. It then deserializes the `DATA_W` bits the reader shifts out and returns the word with a one-cycle response pulse. The block sits between the requesting engines and the reader controller. It is the only agent allowed to drive the reader's `read_en` and address.

---
 rtl/nvm_read_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_nvm_read_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvm_read_arbiter.sv
// rtl/nvm_read_arbiter.sv - round-robin arbiter sharing one serial NVM reader
//
// Grants one of NUM_REQ requesters at a time, pulses read_en with the latched
// word address, deserializes DATA_W bits (MSB first) from the reader and
// returns the word with a one-cycle response pulse. A transaction that runs
// TIMEOUT cycles past ISSUE is answered with rsp_err=1 and zero data.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req, req_addr     per-requester request level and packed word addresses
//   gnt               one-hot grant, held from ISSUE through RESP
//   rsp_valid/id/data/err  one-cycle response
//   read_en, nvm_addr read start pulse and address to the reader controller
//   load, shift, sdata     strobes and serial data from the reader controller
module nvm_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_REQ-1:0]                            req,
  input  logic [NUM_REQ*ADDR_W-1:0]                     req_addr,
  output logic [NUM_REQ-1:0]                            gnt,
  output logic                                          rsp_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
  output logic [DATA_W-1:0]                             rsp_data,
  output logic                                          rsp_err,
  output logic                                          read_en,
  output logic [ADDR_W-1:0]                             nvm_addr,
  input  logic                                          load,
  input  logic                                          shift,
  input  logic                                          sdata
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BCW = $clog2(DATA_W + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOAD,
    S_SHIFT,
    S_RESP
  } state_t;

  state_t              state, state_nxt;
  logic [IDW-1:0]      ptr, ptr_nxt;
  logic [NUM_REQ-1:0]  gnt_nxt;
  logic [IDW-1:0]      id_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                err_nxt;
  logic [BCW-1:0]      bit_cnt, bit_cnt_nxt;
  logic [TCW-1:0]      tmo_cnt, tmo_cnt_nxt;
  logic                read_en_nxt;
  logic                rsp_valid_nxt;

  // Round-robin pick: first set req bit scanning upward from ptr, with wrap.
  logic                found;
  logic [IDW-1:0]      win;
  logic [IDW-1:0]      scan;
  logic [ADDR_W-1:0]   win_addr;

  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan     = ptr;
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[scan]) begin
        found = 1'b1;
        win   = scan;
      end
      scan = (int'(scan) == NUM_REQ - 1) ? '0 : scan + IDW'(1);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IDW'(i)) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    gnt_nxt       = gnt;
    id_nxt        = rsp_id;
    addr_nxt      = nvm_addr;
    shreg_nxt     = shreg;
    data_nxt      = rsp_data;
    err_nxt       = rsp_err;
    bit_cnt_nxt   = bit_cnt;
    tmo_cnt_nxt   = tmo_cnt;
    read_en_nxt   = 1'b0;
    rsp_valid_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt   = S_ISSUE;
          id_nxt      = win;
          addr_nxt    = win_addr;
          read_en_nxt = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            gnt_nxt[i] = (win == IDW'(i));
          end
        end
      end

      S_ISSUE: begin
        state_nxt   = S_WAIT_LOAD;
        bit_cnt_nxt = '0;
        tmo_cnt_nxt = '0;
        shreg_nxt   = '0;
      end

      S_WAIT_LOAD: begin
        tmo_cnt_nxt = tmo_cnt + TCW'(1);
        if (tmo_cnt_nxt == TCW'(TIMEOUT)) begin
          state_nxt     = S_RESP;
          rsp_valid_nxt = 1'b1;
          err_nxt       = 1'b1;
          data_nxt      = '0;
        end else if (load) begin
          state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        tmo_cnt_nxt = tmo_cnt + TCW'(1);
        if (shift) begin
          shreg_nxt   = {shreg[DATA_W-2:0], sdata};
          bit_cnt_nxt = bit_cnt + BCW'(1);
        end
        // The last data bit takes precedence over a timeout on the same edge.
        if (shift && bit_cnt == BCW'(DATA_W - 1)) begin
          state_nxt     = S_RESP;
          rsp_valid_nxt = 1'b1;
          err_nxt       = 1'b0;
          data_nxt      = shreg_nxt;
        end else if (tmo_cnt_nxt == TCW'(TIMEOUT)) begin
          state_nxt     = S_RESP;
          rsp_valid_nxt = 1'b1;
          err_nxt       = 1'b1;
          data_nxt      = '0;
        end
      end

      S_RESP: begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
        data_nxt  = '0;
        err_nxt   = 1'b0;
        ptr_nxt   = (int'(rsp_id) == NUM_REQ - 1) ? '0 : rsp_id + IDW'(1);
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      rsp_id    <= '0;
      nvm_addr  <= '0;
      shreg     <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      read_en   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      rsp_id    <= id_nxt;
      nvm_addr  <= addr_nxt;
      shreg     <= shreg_nxt;
      rsp_data  <= data_nxt;
      rsp_err   <= err_nxt;
      bit_cnt   <= bit_cnt_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      read_en   <= read_en_nxt;
      rsp_valid <= rsp_valid_nxt;
    end
  end

endmodule

// File: tb/tb_nvm_read_arbiter.sv
// tb/tb_nvm_read_arbiter.sv - scoreboard bench for nvm_read_arbiter
module tb_nvm_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 64;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rsp_valid;
  logic [1:0]                rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      read_en;
  logic [ADDR_W-1:0]         nvm_addr;
  logic                      load;
  logic                      shift;
  logic                      sdata;

  nvm_read_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .read_en  (read_en),
    .nvm_addr (nvm_addr),
    .load     (load),
    .shift    (shift),
    .sdata    (sdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        err;
    int          lat;
    bit          b2b;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] mem[64];
  bit          rd_no_load = 1'b0;
  int          rd_gap_at  = -1;
  int          rd_gap_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_tx(input int id, input logic [5:0] addr, input logic err,
                           input int lat, input bit b2b);
    exp_t e;
    e.id   = id;
    e.addr = addr;
    e.err  = err;
    e.data = err ? 16'h0000 : mem[addr];
    e.lat  = lat;
    e.b2b  = b2b;
    q.push_back(e);
  endtask

  task automatic set_addr(input int i, input logic [5:0] a);
    req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic monitor();
    exp_t e;
    int   issue_cyc    = 0;
    int   last_rsp_cyc = -100;
    logic prev_read_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (read_en) begin
          chk("read_en_single_cycle", prev_read_en, 0);
          if (q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_read_en: got gnt 0x%0h expected no transaction", gnt);
          end else begin
            chk("issue_gnt", gnt, 32'd1 << q[0].id);
            chk("issue_addr", nvm_addr, q[0].addr);
            if (q[0].b2b) chk("b2b_spacing", cyc - last_rsp_cyc, 2);
            issue_cyc = cyc;
          end
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_rsp: got id %0d expected no response", rsp_id);
          end else begin
            e = q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_latency", cyc - issue_cyc, e.lat);
            chk("rsp_gnt_held", gnt, 32'd1 << e.id);
            chk("rsp_addr_held", nvm_addr, e.addr);
          end
          last_rsp_cyc = cyc;
        end
        prev_read_en = read_en;
      end else begin
        prev_read_en = 1'b0;
      end
    end
  endtask

  // Requester model: drop req once its response has been seen.
  task automatic dropper();
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) req[rsp_id] = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL wait_done: got %0d pending responses expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_read_en();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!read_en && n < 20);
    if (!read_en) begin
      n_vec++; n_bad++;
      $display("FAIL wait_read_en: got read_en 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_read_en"}, read_en, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_nvm_addr"}, nvm_addr, 0);
  endtask

  // Reader controller model: one cycle after read_en it strobes load, then
  // shifts the stored word MSB first, optionally with a gap before bit rd_gap_at.
  task automatic serve(input logic [15:0] w);
    @(negedge clk);
    if (!rst_n) return;
    load = 1'b1;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      load = 1'b0;
      if (!rst_n) begin
        shift = 1'b0;
        return;
      end
      if (b == rd_gap_at) begin
        for (int g = 0; g < rd_gap_len; g++) begin
          shift = 1'b0;
          load  = 1'b1;
          sdata = ~w[15-b];
          @(negedge clk);
          if (!rst_n) begin
            shift = 1'b0;
            load  = 1'b0;
            return;
          end
        end
        load = 1'b0;
      end
      shift = 1'b1;
      sdata = w[15-b];
    end
    @(negedge clk);
    shift = 1'b0;
  endtask

  initial begin
    load  = 1'b0;
    shift = 1'b0;
    sdata = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && read_en && !rd_no_load) serve(mem[nvm_addr]);
    end
  end

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[6'h01] = 16'h8001;
    mem[6'h2A] = 16'h7FFE;
    mem[6'h15] = 16'hA5C3;
    mem[6'h3F] = 16'h0F0F;
    mem[6'h22] = 16'h1234;
    mem[6'h0B] = 16'h5A5A;
    set_addr(0, 6'h01);
    set_addr(1, 6'h2A);
    set_addr(2, 6'h15);
    set_addr(3, 6'h3F);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    fork
      monitor();
      dropper();
    join_none

    // Fairness from reset: 0,1,2,3 back to back.
    expect_tx(0, 6'h01, 1'b0, 18, 1'b0);
    expect_tx(1, 6'h2A, 1'b0, 18, 1'b1);
    expect_tx(2, 6'h15, 1'b0, 18, 1'b1);
    expect_tx(3, 6'h3F, 1'b0, 18, 1'b1);
    rst_n = 1'b1;
    req   = 4'b1111;
    wait_done(300);

    // Single request; address changes after the grant must not matter.
    expect_tx(2, 6'h15, 1'b0, 18, 1'b0);
    req = 4'b0100;
    wait_read_en();
    set_addr(2, 6'h00);
    wait_done(100);
    set_addr(2, 6'h15);

    // ptr is 3 after serving id 2: id 3 goes before id 1.
    expect_tx(3, 6'h3F, 1'b0, 18, 1'b0);
    expect_tx(1, 6'h2A, 1'b0, 18, 1'b1);
    req = 4'b1010;
    wait_done(200);

    // Three gap cycles between bits 7 and 8.
    set_addr(0, 6'h22);
    rd_gap_at  = 8;
    rd_gap_len = 3;
    expect_tx(0, 6'h22, 1'b0, 21, 1'b0);
    req = 4'b0001;
    wait_done(100);
    rd_gap_at = -1;

    // Timeout with load never asserted, then a normal request.
    rd_no_load = 1'b1;
    expect_tx(3, 6'h3F, 1'b1, 65, 1'b0);
    req = 4'b1000;
    wait_done(200);
    rd_no_load = 1'b0;
    set_addr(1, 6'h0B);
    expect_tx(1, 6'h0B, 1'b0, 18, 1'b0);
    req = 4'b0010;
    wait_done(100);

    // Reset after 5 captured bits; ptr (2 here) must return to 0.
    expect_tx(3, 6'h3F, 1'b0, 18, 1'b0);
    req = 4'b1000;
    wait_read_en();
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    q.delete();
    req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_tx(1, 6'h0B, 1'b0, 18, 1'b0);
    expect_tx(3, 6'h3F, 1'b0, 18, 1'b1);
    req = 4'b1010;
    wait_done(200);

    repeat (30) @(negedge clk);
    chk("idle_gnt", gnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
